// File: rtl/cmpr_pkg.sv
// Shared definitions for the pipelined compare macrocell: op encodings,
// the op field width, and the pipeline slot layout.
package cmpr_pkg;

  localparam int CMPR_OP_W = 4;

  typedef enum logic [CMPR_OP_W-1:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_LTU = 4'd2,
    OP_LEU = 4'd3,
    OP_GTU = 4'd4,
    OP_GEU = 4'd5,
    OP_LTS = 4'd6,
    OP_LES = 4'd7,
    OP_GTS = 4'd8,
    OP_GES = 4'd9
  } cmpr_op_e;

  localparam logic [CMPR_OP_W-1:0] OP_LAST_LEGAL = 4'd9;

  typedef struct packed {
    logic pred;
    logic res;
  } stage_t;

endpackage

// File: rtl/cmpr_pipe_stage.sv
// One stall-aware pipeline register holding a {pred, res} slot.
module cmpr_pipe_stage
  import cmpr_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stall ? stage_q : d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q;

endmodule

// File: rtl/cmpr_pipe.sv
// Pipelined multi-mode integer comparator with predicate and global stall.
// Define CMPR_PIPE_SIGNED_EN for two's-complement ops 6..9; otherwise they alias 2..5.
module cmpr_pipe
  import cmpr_pkg::*;
#(
  parameter int width   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 pred,
  input  logic [CMPR_OP_W-1:0] op,
  input  logic [width-1:0]     i0,
  input  logic [width-1:0]     i1,
  output logic                 o0_enable,
  output logic [width-1:0]     o0,
  output logic                 err
);

  logic eq, lt_u, lt_s, illegal, cmp, res;
  logic err_d, err_q;
  stage_t [LATENCY:0] chain;

  assign eq   = (i0 == i1);
  assign lt_u = (i0 < i1);
`ifdef CMPR_PIPE_SIGNED_EN
  // At width 1 the lone bit is the sign, so 1 < 0 holds.
  assign lt_s = ($signed(i0) < $signed(i1));
`else
  assign lt_s = lt_u;
`endif
  assign illegal = (op > OP_LAST_LEGAL);

  always_comb begin
    cmp = 1'b0;
    case (op)
      OP_EQ:   cmp = eq;
      OP_NE:   cmp = !eq;
      OP_LTU:  cmp = lt_u;
      OP_LEU:  cmp = lt_u | eq;
      OP_GTU:  cmp = !(lt_u | eq);
      OP_GEU:  cmp = !lt_u;
      OP_LTS:  cmp = lt_s;
      OP_LES:  cmp = lt_s | eq;
      OP_GTS:  cmp = !(lt_s | eq);
      OP_GES:  cmp = !lt_s;
      default: cmp = 1'b0;
    endcase
  end

  assign res = pred & !illegal & cmp;

  always_comb begin
    err_d = err_q | (!stall & pred & illegal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign chain[0] = '{pred: pred, res: res};

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    cmpr_pipe_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .d     (chain[g]),
      .q     (chain[g+1])
    );
  end

  assign o0_enable = chain[LATENCY].pred;
  assign o0        = width'(chain[LATENCY].res);
  assign err       = err_q;

endmodule

// File: tb/tb_cmpr_pipe.sv
// Directed bench for cmpr_pipe at width=8, LATENCY=2.
module tb_cmpr_pipe;

  logic       clk = 1'b0;
  logic       rst_n, stall, pred;
  logic [3:0] op;
  logic [7:0] i0, i1;
  logic       o0_enable, err;
  logic [7:0] o0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmpr_pipe #(.width(8), .LATENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pred      (pred),
    .op        (op),
    .i0        (i0),
    .i1        (i1),
    .o0_enable (o0_enable),
    .o0        (o0),
    .err       (err)
  );

`ifdef CMPR_PIPE_SIGNED_EN
  logic [7:0] sweep_exp [10] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
`else
  logic [7:0] sweep_exp [10] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
`endif
  logic [3:0] edge_op  [6] = '{4'd0, 4'd3, 4'd5, 4'd7, 4'd9, 4'd1};
  logic [7:0] edge_exp [6] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};

  task automatic drive(input logic p, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    pred = p; op = o; i0 = a; i1 = b;
  endtask

  task automatic flush();
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    #3;
    total++;
    if (o0 !== 8'd0 || o0_enable !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset: o0=%h en=%b err=%b, want o0=00 en=0 err=0", o0, o0_enable, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mode_sweep();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        total++;
        if (o0 !== sweep_exp[j-2] || o0_enable !== 1'b1) begin
          bad++;
          $display("FAIL sweep op%0d: o0=%h en=%b, want o0=%h en=1", j-2, o0, o0_enable, sweep_exp[j-2]);
        end
      end
      if (j < 10) drive(1'b1, 4'(j), 8'h80, 8'h01);
      else        drive(1'b0, 4'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_eq_edge();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        total++;
        if (o0 !== edge_exp[j-2] || o0_enable !== 1'b1) begin
          bad++;
          $display("FAIL eq_edge op%0d: o0=%h en=%b, want o0=%h en=1", edge_op[j-2], o0, o0_enable, edge_exp[j-2]);
        end
      end
      if (j < 6) drive(1'b1, edge_op[j], 8'hFF, 8'hFF);
      else       drive(1'b0, 4'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_pred_off();
    flush();
    drive(1'b0, 4'd0, 8'd3, 8'd3);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    @(negedge clk);
    total++;
    if (o0 !== 8'd0 || o0_enable !== 1'b0) begin
      bad++;
      $display("FAIL pred_off: o0=%h en=%b, want o0=00 en=0", o0, o0_enable);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    flush();
    drive(1'b1, 4'd0, 8'd5, 8'd5);
    @(negedge clk);
    // Illegal op presented while stalled must be ignored, including by err.
    stall = 1'b1;
    drive(1'b1, 4'd12, 8'd9, 8'd9);
    held = o0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (o0 !== held || o0_enable !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold c%0d: o0=%h en=%b err=%b, want o0=%h en=0 err=0", k, o0, o0_enable, err, held);
      end
    end
    stall = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    @(negedge clk);
    total++;
    if (o0_enable !== 1'b1 || o0 !== 8'd1) begin
      bad++;
      $display("FAIL stall_release: o0=%h en=%b, want o0=01 en=1", o0, o0_enable);
    end
    @(negedge clk);
    total++;
    if (o0_enable !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL stall_after: en=%b err=%b, want en=0 err=0", o0_enable, err);
    end
  endtask

  task automatic test_illegal();
    flush();
    drive(1'b0, 4'd12, 8'd1, 8'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_nopred: err=%b, want 0", err);
    end
    drive(1'b1, 4'd12, 8'd1, 8'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_err: err=%b, want 1", err);
    end
    @(negedge clk);
    total++;
    if (o0 !== 8'd0 || o0_enable !== 1'b1) begin
      bad++;
      $display("FAIL illegal_slot: o0=%h en=%b, want o0=00 en=1", o0, o0_enable);
    end
    repeat (2) @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky: err=%b, want 1", err);
    end
  endtask

  task automatic test_reset_midflight();
    flush();
    drive(1'b1, 4'd0, 8'd3, 8'd3);
    @(negedge clk);
    drive(1'b1, 4'd1, 8'd3, 8'd4);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    total++;
    if (o0 !== 8'd1 || o0_enable !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL midflight_pre: o0=%h en=%b err=%b, want o0=01 en=1 err=1", o0, o0_enable, err);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o0 !== 8'd0 || o0_enable !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midflight_async: o0=%h en=%b err=%b, want all 0", o0, o0_enable, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (o0_enable !== 1'b0 || o0 !== 8'd0) begin
        bad++;
        $display("FAIL midflight_post c%0d: o0=%h en=%b, want o0=00 en=0", k, o0, o0_enable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_sweep();
    test_eq_edge();
    test_pred_off();
    test_stall();
    test_illegal();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
